// File: rtl/multi_buffer_pkg.sv
// multi_buffer_pkg: shared bank index type, bank wrap helper and swap FSM states.
package multi_buffer_pkg;
    localparam int MAX_BANKS = 4;
    typedef logic [$clog2(MAX_BANKS)-1:0] bank_idx_t;
    typedef enum logic {IDLE, PENDING} swap_state_t;
    function automatic bank_idx_t next_bank(input bank_idx_t idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : bank_idx_t'(idx + 2'd1);
    endfunction
endpackage

// File: rtl/multi_buffer_bank_ram.sv
// bank_ram: one bank, single write port feeding two replicated simple-dual-port RAMs
// so each read port gets its own registered output.
module bank_ram #(
    parameter int ADDR_SIZE  = 12,
    parameter int LINE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [LINE_WIDTH-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0]  rd_addr_a,
    input  logic [ADDR_SIZE-1:0]  rd_addr_b,
    output logic [LINE_WIDTH-1:0] rd_data_a,
    output logic [LINE_WIDTH-1:0] rd_data_b
);
    logic [LINE_WIDTH-1:0] mem_a [2**ADDR_SIZE];
    logic [LINE_WIDTH-1:0] mem_b [2**ADDR_SIZE];
    always_ff @(posedge clk) begin
        if (we) begin
            mem_a[wr_addr] <= wr_data;
            mem_b[wr_addr] <= wr_data;
        end
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
    end
endmodule

// File: rtl/multi_buffer.sv
// multi_buffer: N-bank generation buffer with frame-sync-committed swaps.
// MULTI_BUFFER_CLEAR_ON_SWAP_EN enables a zero sweep of the new write bank after each commit.
module multi_buffer
    import multi_buffer_pkg::*;
#(
    parameter int ADDR_SIZE  = 12,
    parameter int LINE_WIDTH = 8,
    parameter int NUM_BANKS  = 2,
    parameter int GEN_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  swap_in,
    input  logic                  frame_sync_in,
    input  logic [ADDR_SIZE-1:0]  render_addr_r,
    input  logic [ADDR_SIZE-1:0]  logic_addr_r,
    input  logic [ADDR_SIZE-1:0]  logic_addr_w,
    input  logic [LINE_WIDTH-1:0] logic_data_w,
    input  logic                  logic_wr_en,
    output logic [LINE_WIDTH-1:0] render_data_r,
    output logic [LINE_WIDTH-1:0] logic_data_r,
    output logic                  swap_pending_out,
    output logic                  swap_done_out,
    output logic                  busy_out,
    output logic [GEN_WIDTH-1:0]  gen_count_out
);
    swap_state_t state, state_next;
    bank_idx_t rd_idx, wr_idx, sel_q;
    logic commit, busy, zero_q, we;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [LINE_WIDTH-1:0] wr_data;
    logic [LINE_WIDTH-1:0] render_q [MAX_BANKS];
    logic [LINE_WIDTH-1:0] logic_q [MAX_BANKS];

    always_ff @(posedge clk_in) begin
        state <= rst_in ? IDLE : state_next;
    end

    always_comb begin
        commit     = frame_sync_in && !busy && (state == PENDING || swap_in);
        state_next = commit ? IDLE : (swap_in ? PENDING : state);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_idx        <= '0;
            wr_idx        <= bank_idx_t'(1);
            gen_count_out <= '0;
            swap_done_out <= 1'b0;
            sel_q         <= '0;
            zero_q        <= 1'b1;
        end else begin
            if (commit) begin
                rd_idx        <= wr_idx;
                wr_idx        <= next_bank(wr_idx, NUM_BANKS);
                gen_count_out <= gen_count_out + 1'b1;
            end
            swap_done_out <= commit;
            sel_q         <= rd_idx;
            zero_q        <= 1'b0;
        end
    end

`ifdef MULTI_BUFFER_CLEAR_ON_SWAP_EN
    logic [ADDR_SIZE-1:0] clr_addr;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy     <= 1'b0;
            clr_addr <= '0;
        end else if (commit) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy) begin
            busy     <= clr_addr != '1;
            clr_addr <= clr_addr + 1'b1;
        end
    end
    assign we      = !rst_in && (busy || logic_wr_en);
    assign wr_addr = busy ? clr_addr : logic_addr_w;
    assign wr_data = busy ? '0 : logic_data_w;
`else
    assign busy    = 1'b0;
    assign we      = !rst_in && logic_wr_en;
    assign wr_addr = logic_addr_w;
    assign wr_data = logic_data_w;
`endif

    for (genvar b = 0; b < MAX_BANKS; b++) begin : g_bank
        if (b < NUM_BANKS) begin : g_ram
            bank_ram #(.ADDR_SIZE(ADDR_SIZE), .LINE_WIDTH(LINE_WIDTH)) u_ram (
                .clk       (clk_in),
                .we        (we && wr_idx == bank_idx_t'(b)),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .rd_addr_a (render_addr_r),
                .rd_addr_b (logic_addr_r),
                .rd_data_a (render_q[b]),
                .rd_data_b (logic_q[b])
            );
        end else begin : g_none
            assign render_q[b] = '0;
            assign logic_q[b]  = '0;
        end
    end

    assign render_data_r    = zero_q ? '0 : render_q[sel_q];
    assign logic_data_r     = zero_q ? '0 : logic_q[sel_q];
    assign swap_pending_out = state == PENDING;
    assign busy_out         = busy;
endmodule
